// File: rtl/put_cmd_pkg.sv
// put_cmd_pkg: shared field offsets, FSM state type and register indices for the put-data command splitter
package put_cmd_pkg;
    localparam int PUT_CMD_LEN_LSB = 0;
    localparam int ADDR_LO_LSB     = 32;
    localparam int ADDR_HI_LSB     = 64;
    localparam int PUT_CMD_W       = 96;

    localparam int CTRL_ADDR_LO   = 0;
    localparam int CTRL_ADDR_HI   = 1;
    localparam int CTRL_TOTAL_LEN = 2;
    localparam int CTRL_CHUNK_LEN = 3;
    localparam int CTRL_START     = 4;

    localparam int STAT_ISSUED = 0;
    localparam int STAT_FLAGS  = 1;

    typedef enum logic [1:0] {IDLE, CALC, ISSUE, WAIT_DONE} put_cmd_state_t;
endpackage

// File: rtl/put_data_cmd_splitter.sv
// put_data_cmd_splitter: splits one host transfer into credit-limited put-data commands.
// Define PUT_CMD_4K_SPLIT_EN to keep every command inside one 4 KB address page.
module put_data_cmd_splitter
    import put_cmd_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CHUNK_DEFAULT   = 4096
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [31:0]          control_reg [16],
    output logic                 m_axis_put_data_cmd_valid,
    input  logic                 m_axis_put_data_cmd_ready,
    output logic [PUT_CMD_W-1:0] m_axis_put_data_cmd_data,
    input  logic                 cmpl_valid,
    output logic [31:0]          status_reg [2]
);
    put_cmd_state_t state;
    logic [63:0] addr;
    logic [31:0] remaining, chunk, issued, page_left, cur_len, sent_len;
    logic [15:0] outstanding;
    logic [13:0] err_cnt;
    logic        done, busy, start_q, start_edge, fire, cmpl_ok, unused_ctrl;

    function automatic logic [31:0] min3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        logic [31:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

`ifdef PUT_CMD_4K_SPLIT_EN
    assign page_left = 32'd4096 - {20'd0, addr[11:0]};
`else
    assign page_left = '1;
`endif

    assign cur_len    = min3(remaining, chunk, page_left);
    assign sent_len   = m_axis_put_data_cmd_data[PUT_CMD_LEN_LSB +: 32];
    assign start_edge = control_reg[CTRL_START][0] & ~start_q;
    assign fire       = m_axis_put_data_cmd_valid & m_axis_put_data_cmd_ready;
    assign cmpl_ok    = cmpl_valid & (outstanding != 16'd0);

    always_comb begin
        status_reg[STAT_ISSUED] = issued;
        status_reg[STAT_FLAGS]  = {done, busy, err_cnt, outstanding};
    end

    always_comb begin
        unused_ctrl = ^control_reg[CTRL_START][31:1];
        for (int i = 5; i < 16; i++) unused_ctrl = unused_ctrl ^ (^control_reg[i]);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state                     <= IDLE;
            m_axis_put_data_cmd_valid <= 1'b0;
            m_axis_put_data_cmd_data  <= '0;
            addr                      <= '0;
            remaining                 <= '0;
            chunk                     <= '0;
            issued                    <= '0;
            outstanding               <= '0;
            err_cnt                   <= '0;
            done                      <= 1'b0;
            busy                      <= 1'b0;
            start_q                   <= 1'b0;
        end else begin
            start_q     <= control_reg[CTRL_START][0];
            outstanding <= outstanding + 16'(fire) - 16'(cmpl_ok);
            if (cmpl_valid && outstanding == 16'd0 && err_cnt != 14'h3FFF)
                err_cnt <= err_cnt + 14'd1;
            case (state)
                IDLE: if (start_edge) begin
                    addr      <= {control_reg[CTRL_ADDR_HI], control_reg[CTRL_ADDR_LO]};
                    remaining <= control_reg[CTRL_TOTAL_LEN];
                    chunk     <= (control_reg[CTRL_CHUNK_LEN] == 32'd0) ? 32'(CHUNK_DEFAULT)
                                                                        : control_reg[CTRL_CHUNK_LEN];
                    done      <= 1'b0;
                    busy      <= 1'b1;
                    issued    <= '0;
                    err_cnt   <= '0;
                    state     <= CALC;
                end
                CALC: if (remaining == 32'd0) begin
                    state <= WAIT_DONE;
                end else if (outstanding != 16'(MAX_OUTSTANDING)) begin
                    m_axis_put_data_cmd_data  <= {addr, cur_len};
                    m_axis_put_data_cmd_valid <= 1'b1;
                    state                     <= ISSUE;
                end
                ISSUE: if (m_axis_put_data_cmd_ready) begin
                    addr                      <= addr + {32'd0, sent_len};
                    remaining                 <= remaining - sent_len;
                    issued                    <= issued + 32'd1;
                    m_axis_put_data_cmd_valid <= 1'b0;
                    state                     <= CALC;
                end
                WAIT_DONE: if (outstanding == 16'd0) begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_put_data_cmd_splitter.sv
// tb_put_data_cmd_splitter: scoreboard bench for put_data_cmd_splitter (MAX_OUTSTANDING=2)
module tb_put_data_cmd_splitter;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] control_reg [16];
    logic        valid, ready, cmpl_valid, cmpl_auto, cmpl_man;
    logic [95:0] data;
    logic [31:0] status_reg [2];

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;
    int exp_issued;
    logic [95:0] sb [$];
    int cmpl_q [$];
    logic auto_en;

    assign cmpl_valid = cmpl_auto | cmpl_man;

    put_data_cmd_splitter #(.MAX_OUTSTANDING(2), .CHUNK_DEFAULT(4096)) dut (
        .clk                       (clk),
        .rstn                      (rstn),
        .control_reg               (control_reg),
        .m_axis_put_data_cmd_valid (valid),
        .m_axis_put_data_cmd_ready (ready),
        .m_axis_put_data_cmd_data  (data),
        .cmpl_valid                (cmpl_valid),
        .status_reg                (status_reg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Handshake occurs on the next posedge; inputs are stable at negedge.
    always @(negedge clk) begin
        if (rstn && valid && ready) begin
            if (sb.size() == 0) chk("cmd_unexpected", valid, 1'b0);
            else chk("cmd", data, sb.pop_front());
            if (auto_en) cmpl_q.push_back(cyc + 4);
        end
    end

    always @(posedge clk) begin
        #1;
        cmpl_auto = 1'b0;
        if (cmpl_q.size() > 0 && cmpl_q[0] <= cyc) begin
            cmpl_auto = 1'b1;
            void'(cmpl_q.pop_front());
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic start_xfer(input logic [31:0] lo, hi, len, chk_len);
        logic [63:0] a;
        logic [31:0] rem, ch, l;
        control_reg[0] = lo;
        control_reg[1] = hi;
        control_reg[2] = len;
        control_reg[3] = chk_len;
        a = {hi, lo};
        rem = len;
        ch = (chk_len == 0) ? 32'd4096 : chk_len;
        exp_issued = 0;
        while (rem != 0) begin
            l = (rem < ch) ? rem : ch;
`ifdef PUT_CMD_4K_SPLIT_EN
            if (32'd4096 - {20'd0, a[11:0]} < l) l = 32'd4096 - {20'd0, a[11:0]};
`endif
            sb.push_back({a, l});
            a = a + {32'd0, l};
            rem = rem - l;
            exp_issued++;
        end
        control_reg[4] = 32'd1;
        cycles(1);
        control_reg[4] = 32'd0;
        control_reg[2] = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (!status_reg[1][31] && i < budget) begin cycles(1); i++; end
        chk({tag, "_done"}, status_reg[1][31], 1'b1);
        chk({tag, "_issued"}, status_reg[0], exp_issued);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        logic [95:0] held;
        int i;
        rstn = 1'b0; ready = 1'b0; cmpl_man = 1'b0; cmpl_auto = 1'b0; auto_en = 1'b1;
        for (int k = 0; k < 16; k++) control_reg[k] = '0;
        cycles(3);
        chk("rst_valid", valid, 1'b0);
        chk("rst_data", data, 96'd0);
        chk("rst_stat0", status_reg[0], 32'd0);
        chk("rst_stat1", status_reg[1], 32'd0);
        rstn = 1'b1;
        cycles(2);

        ready = 1'b1;
        start_xfer(32'h1234_0000, 32'h1, 32'h3000, 32'h1000);
        wait_done("basic", 200);
        chk("basic_outstanding", status_reg[1][15:0], 16'd0);

        start_xfer(32'h0, 32'h0, 32'h2800, 32'h1000);
        wait_done("tail", 200);

        auto_en = 1'b0;
        start_xfer(32'h0, 32'h0, 32'h4000, 32'h1000);
        cycles(20);
        chk("credit_issued", status_reg[0], 32'd2);
        chk("credit_outstanding", status_reg[1][15:0], 16'd2);
        chk("credit_sb_left", sb.size(), 2);
        cmpl_man = 1'b1; cycles(1); cmpl_man = 1'b0;
        cycles(6);
        chk("credit_third", status_reg[0], 32'd3);
        chk("credit_not_done", status_reg[1][31], 1'b0);
        i = 0;
        while (!status_reg[1][31] && i < 10) begin
            cmpl_man = 1'b1; cycles(1); cmpl_man = 1'b0;
            cycles(3);
            i++;
        end
        wait_done("credit", 10);
        auto_en = 1'b1;

        ready = 1'b0;
        start_xfer(32'h0000_8000, 32'h0, 32'h1000, 32'h0);
        i = 0;
        while (!valid && i < 10) begin cycles(1); i++; end
        held = data;
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid", valid, 1'b1);
            chk("stall_data", data, held);
            cycles(1);
        end
        ready = 1'b1;
        wait_done("stall", 50);

        start_xfer(32'h0, 32'h0, 32'h0, 32'h1000);
        chk("zero_valid", valid, 1'b0);
        cycles(1);
        chk("zero_done_early", status_reg[1][31], 1'b0);
        cycles(1);
        chk("zero_done", status_reg[1][31], 1'b1);
        chk("zero_valid2", valid, 1'b0);
        cmpl_man = 1'b1; cycles(1); cmpl_man = 1'b0;
        cycles(1);
        chk("stray_err_cnt", status_reg[1][29:16], 14'd1);
        chk("stray_outstanding", status_reg[1][15:0], 16'd0);

        start_xfer(32'h0000_0F00, 32'h0, 32'h1000, 32'h1000);
        wait_done("page", 100);

        start_xfer(32'hFFFF_F000, 32'hFFFF_FFFF, 32'h2000, 32'h1000);
        wait_done("wrap", 100);

        start_xfer(32'h0, 32'h0, 32'h4000, 32'h1000);
        i = 0;
        while (status_reg[0] == 0 && i < 20) begin cycles(1); i++; end
        rstn = 1'b0;
        cycles(1);
        sb.delete();
        cmpl_q.delete();
        chk("abort_valid", valid, 1'b0);
        chk("abort_stat0", status_reg[0], 32'd0);
        chk("abort_stat1", status_reg[1], 32'd0);
        rstn = 1'b1;
        cycles(5);
        chk("abort_idle_valid", valid, 1'b0);
        start_xfer(32'h1234_0000, 32'h1, 32'h3000, 32'h1000);
        wait_done("restart", 200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
